// File: rtl/fp_norm_round_28.sv
// Two-stage normalize / round-to-nearest-even / pack stage for the binary32 adder.
// Define NR_FLAGS_EN to add the FLAGS {OVF, UNF, ZERO, INEXACT} output and its registers.
module fp_norm_round_28 (
    input  logic        CLK,
    input  logic        RST,
    input  logic [27:0] SUM,
    input  logic [7:0]  EXP,
    input  logic        SIGN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [31:0] RESULT,
    output logic        OUT_VALID,
`ifdef NR_FLAGS_EN
    output logic [3:0]  FLAGS,
`endif
    input  logic        OUT_READY
);

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s1_advance;
    logic in_fire;

    assign s1_advance = s1_valid_q & (~out_valid_q | OUT_READY);
    assign IN_READY   = ~s1_valid_q | s1_advance;
    assign in_fire    = IN_VALID & IN_READY;

    always_comb begin
        s1_valid_d  = in_fire | (s1_valid_q & ~s1_advance);
        out_valid_d = s1_advance | (out_valid_q & ~OUT_READY);
    end

    // Stage 1: normalize
    logic [4:0]        lz;
    logic [26:0]       shl;
    logic signed [9:0] s1_exp_d;
    logic [22:0]       s1_frac_d;
    logic              s1_g_d, s1_r_d, s1_s_d;
    logic              s1_zero_d, s1_unf_d;

    always_comb begin
        lz = '0;
        // Ascending scan: the last hit is the most significant set bit.
        for (int i = 0; i < 27; i++) begin
            if (SUM[i]) lz = 5'(26 - i);
        end
        shl      = SUM[26:0] << lz;
        s1_exp_d = $signed({2'b00, EXP});
        if (SUM[27]) begin
            s1_frac_d = SUM[26:4];
            s1_g_d    = SUM[3];
            s1_r_d    = SUM[2];
            s1_s_d    = SUM[1] | SUM[0];
            s1_exp_d  = s1_exp_d + 10'sd1;
        end else begin
            s1_frac_d = shl[25:3];
            s1_g_d    = shl[2];
            s1_r_d    = shl[1];
            s1_s_d    = shl[0];
            s1_exp_d  = s1_exp_d - $signed({5'b00000, lz});
        end
        s1_zero_d = (SUM == '0);
        s1_unf_d  = ~s1_zero_d & (s1_exp_d <= 10'sd0);
    end

    logic              s1_sign_q;
    logic signed [9:0] s1_exp_q;
    logic [22:0]       s1_frac_q;
    logic              s1_g_q, s1_r_q, s1_s_q;
    logic              s1_zero_q, s1_unf_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_g_q     <= 1'b0;
            s1_r_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_unf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_sign_q <= SIGN;
                s1_exp_q  <= s1_exp_d;
                s1_frac_q <= s1_frac_d;
                s1_g_q    <= s1_g_d;
                s1_r_q    <= s1_r_d;
                s1_s_q    <= s1_s_d;
                s1_zero_q <= s1_zero_d;
                s1_unf_q  <= s1_unf_d;
            end
        end
    end

    // Stage 2: round and pack
    logic              rnd_inc;
    logic [23:0]       frac_rnd;
    logic signed [9:0] r_exp;
    logic              r_ovf;
    logic [31:0]       result_d;

    always_comb begin
        rnd_inc  = s1_g_q & (s1_r_q | s1_s_q | s1_frac_q[0]);
        frac_rnd = {1'b0, s1_frac_q} + {23'b0, rnd_inc};
        r_exp    = s1_exp_q + $signed({9'b0, frac_rnd[23]});
        r_ovf    = (r_exp >= 10'sd255);
        result_d = {s1_sign_q, r_exp[7:0], frac_rnd[22:0]};
        if (s1_zero_q) begin
            result_d = '0;
        end else if (s1_unf_q) begin
            result_d = {s1_sign_q, 31'b0};
        end else if (r_ovf) begin
            result_d = {s1_sign_q, 8'hFF, 23'b0};
        end
    end

    logic [31:0] result_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_advance) result_q <= result_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;

`ifdef NR_FLAGS_EN
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    always_comb begin
        flags_d = {3'b000, s1_g_q | s1_r_q | s1_s_q};
        if (s1_zero_q) begin
            flags_d = 4'b0010;
        end else if (s1_unf_q) begin
            flags_d = 4'b0101;
        end else if (r_ovf) begin
            flags_d = 4'b1001;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q <= '0;
        end else if (s1_advance) begin
            flags_q <= flags_d;
        end
    end

    assign FLAGS = flags_q;
`endif

endmodule

// File: tb/tb_fp_norm_round_28.sv
// Self-checking bench for fp_norm_round_28: directed vectors, backpressure, reset and random traffic
// against an arithmetic reference model. Honours NR_FLAGS_EN for the FLAGS port.
module tb_fp_norm_round_28;

    logic        CLK;
    logic        RST;
    logic [27:0] SUM;
    logic [7:0]  EXP;
    logic        SIGN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] RESULT;
    logic        OUT_VALID;
    logic        OUT_READY;
`ifdef NR_FLAGS_EN
    logic [3:0]  FLAGS;
`endif

    int n_chk;
    int n_pass;
    int n_acc;
    int n_pop;
    logic [35:0] exp_q[$];

    fp_norm_round_28 dut (
        .CLK      (CLK),
        .RST      (RST),
        .SUM      (SUM),
        .EXP      (EXP),
        .SIGN     (SIGN),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .RESULT   (RESULT),
        .OUT_VALID(OUT_VALID),
`ifdef NR_FLAGS_EN
        .FLAGS    (FLAGS),
`endif
        .OUT_READY(OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Value-level model: locate the MSB, scale to 24 significant bits, round the discarded
    // remainder to nearest-even by integer comparison with one half. Returns {flags, word}.
    function automatic logic [35:0] model(input logic [27:0] s, input logic [7:0] e,
                                          input logic sg);
        int p, k, ex;
        longint unsigned q, rem, half;
        logic inx;
        if (s == 0) return {4'b0010, 32'h0};
        p = 0;
        for (int i = 0; i < 28; i++) if (s[i]) p = i;
        ex = int'(e) + p - 26;
        if (ex <= 0) return {4'b0101, sg, 31'h0};
        k   = p - 23;
        q   = 64'(s);
        inx = 1'b0;
        if (k > 0) begin
            rem  = q & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
            q    = q >> k;
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end else begin
            q = q << (-k);
        end
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return {4'b1001, sg, 8'hFF, 23'h0};
        return {3'b000, inx, sg, 8'(ex), q[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_chk++;
        assert (got === want) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock: score the output transfer and record the input transfer at the falling edge.
    task automatic tick();
        logic [35:0] w;
        @(negedge CLK);
        if (OUT_VALID && OUT_READY) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("stray_out", 36'(OUT_VALID), 36'h0);
            end else begin
                w = exp_q.pop_front();
                chk("rand_result", 36'(RESULT), 36'(w[31:0]));
`ifdef NR_FLAGS_EN
                chk("rand_flags", 36'(FLAGS), 36'(w[35:32]));
`endif
            end
        end
        if (IN_VALID && IN_READY) begin
            exp_q.push_back(model(SUM, EXP, SIGN));
            n_acc++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_dir(input string tag, input logic [27:0] s, input logic [7:0] e,
                            input logic sg, input logic [31:0] er, input logic [3:0] ef);
        chk({tag, "_model"}, model(s, e, sg), {ef, er});
        SUM       = s;
        EXP       = e;
        SIGN      = sg;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk({tag, "_inready"}, 36'(IN_READY), 36'h1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk({tag, "_early"}, 36'(OUT_VALID), 36'h0);
        @(posedge CLK);
        #1;
        chk({tag, "_valid"}, 36'(OUT_VALID), 36'h1);
        chk(tag, 36'(RESULT), 36'(er));
`ifdef NR_FLAGS_EN
        chk({tag, "_flags"}, 36'(FLAGS), 36'(ef));
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_inputs();
        logic [27:0] s;
        case ($urandom_range(0, 4))
            0: s = 28'($urandom) | 28'h8000000;
            1: s = (28'($urandom) & 28'h3FFFFFF) | 28'h4000000;
            2: s = (28'($urandom) & 28'h7FFFFFF) >> $urandom_range(0, 26);
            3: s = {2'b01, 23'h7FFFFF, 3'($urandom)};
            default: s = 28'($urandom);
        endcase
        if ($urandom_range(0, 15) == 0) s = '0;
        SUM = s;
        case ($urandom_range(0, 3))
            0: EXP = 8'($urandom_range(1, 3));
            1: EXP = 8'($urandom_range(252, 254));
            default: EXP = 8'($urandom_range(1, 254));
        endcase
        SIGN     = 1'($urandom);
        IN_VALID = 1'($urandom);
    endtask

    initial begin
        int seen;
        n_chk     = 0;
        n_pass    = 0;
        n_acc     = 0;
        n_pop     = 0;
        RST       = 1'b1;
        SUM       = '0;
        EXP       = 8'd1;
        SIGN      = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;

        #2;
        chk("rst_out_valid", 36'(OUT_VALID), 36'h0);
        chk("rst_result", 36'(RESULT), 36'h0);
`ifdef NR_FLAGS_EN
        chk("rst_flags", 36'(FLAGS), 36'h0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rst_in_ready", 36'(IN_READY), 36'h1);

        send_dir("plain",     28'h4000000, 8'd127, 1'b0, 32'h3F800000, 4'b0000);
        send_dir("carry",     28'h8000000, 8'd127, 1'b0, 32'h40000000, 4'b0000);
        send_dir("tie_even",  28'h4000004, 8'd127, 1'b0, 32'h3F800000, 4'b0001);
        send_dir("tie_odd",   28'h400000C, 8'd127, 1'b0, 32'h3F800002, 4'b0001);
        send_dir("rnd_carry", 28'h7FFFFFC, 8'd127, 1'b0, 32'h40000000, 4'b0001);
        send_dir("cancel",    28'h0000008, 8'd127, 1'b0, 32'h34000000, 4'b0000);
        send_dir("underflow", 28'h0000008, 8'd10,  1'b0, 32'h00000000, 4'b0101);
        send_dir("zero",      28'h0000000, 8'd127, 1'b1, 32'h00000000, 4'b0010);
        send_dir("overflow",  28'h8000000, 8'd254, 1'b1, 32'hFF800000, 4'b1001);

        // Backpressure: three offers with the sink stalled
        exp_q.delete();
        n_acc     = 0;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        SUM = 28'h4000000; EXP = 8'd127; SIGN = 1'b0;
        tick();
        SUM = 28'h8000000; EXP = 8'd100; SIGN = 1'b1;
        tick();
        SUM = 28'h5555554; EXP = 8'd130; SIGN = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_accepted", 36'(n_acc), 36'd2);
        chk("bp_in_ready", 36'(IN_READY), 36'h0);
        chk("bp_out_valid", 36'(OUT_VALID), 36'h1);
        chk("bp_hold", 36'(RESULT), 36'(exp_q[0][31:0]));
        tick();
        chk("bp_hold2", 36'(RESULT), 36'(exp_q[0][31:0]));
        OUT_READY = 1'b1;
        n_pop     = 0;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        chk("bp_drained", 36'(n_pop), 36'd3);
        chk("bp_accepted3", 36'(n_acc), 36'd3);
        chk("bp_queue_empty", 36'(exp_q.size()), 36'd0);

        // Random traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            OUT_READY = ($urandom_range(0, 3) != 0);
            tick();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        chk("rand_drain", 36'(exp_q.size()), 36'd0);

        // Reset with two entries in flight
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        SUM = 28'h4000000; EXP = 8'd127; SIGN = 1'b0;
        tick();
        SUM = 28'h4000004; EXP = 8'd127; SIGN = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("mid_full", 36'(OUT_VALID), 36'h1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_async", 36'(OUT_VALID), 36'h0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        OUT_READY = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            if (OUT_VALID) seen++;
            tick();
        end
        chk("mid_no_stale", 36'(seen), 36'd0);
        send_dir("post_rst", 28'h4000000, 8'd127, 1'b0, 32'h3F800000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
